multihand_bank: RTL and testbench

- Parametrised successor to the fixed six-register card datapath: NUM_HANDS hands, each holding up to MAX_CARDS cards.
- Owns a free-running deal counter and appends the current card to a requested hand via a valid/ready handshake.
- Keeps a per-hand baccarat score (mod 10) incrementally, plus count/full/natural flags and a registered card read port for display logic.
- Sits between the game FSM (issues deal/clear requests) and card7seg/score display blocks.

---
 rtl/multihand_bank_if.sv | 47 ++++
 rtl/multihand_bank.sv | 126 ++++++++++++
 tb/tb_multihand_bank.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multihand_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : multihand_bank_if
//  Description : Bundle between the game FSM (master) and the multi-hand
//                card bank (slave). Carries deal/clear requests, the card
//                read port and the per-hand status vectors.
//  Ports       : none; the signals below are grouped by modport.
//                master - drives deal/clear requests and read address,
//                         observes ready, read data, current card, status.
//                slave  - the bank side of the same signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multihand_bank_if #(
    parameter int NUM_HANDS = 2,
    parameter int MAX_CARDS = 3
);
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
    localparam int SW = (MAX_CARDS > 1) ? $clog2(MAX_CARDS) : 1;
    localparam int CW = $clog2(MAX_CARDS + 1);

    logic                    deal_valid;
    logic [HW-1:0]           deal_hand;
    logic                    deal_ready;
    logic                    clear_valid;
    logic [HW-1:0]           clear_hand;
    logic [HW-1:0]           rd_hand;
    logic [SW-1:0]           rd_slot;
    logic [3:0]              rd_card;
    logic [3:0]              new_card;
    logic [4*NUM_HANDS-1:0]  score_out;
    logic [CW*NUM_HANDS-1:0] count_out;
    logic [NUM_HANDS-1:0]    full_out;
    logic [NUM_HANDS-1:0]    natural_out;

    modport master (
        output deal_valid, deal_hand, clear_valid, clear_hand, rd_hand, rd_slot,
        input  deal_ready, rd_card, new_card, score_out, count_out, full_out,
               natural_out
    );

    modport slave (
        input  deal_valid, deal_hand, clear_valid, clear_hand, rd_hand, rd_slot,
        output deal_ready, rd_card, new_card, score_out, count_out, full_out,
               natural_out
    );
endinterface
`default_nettype wire

// File: rtl/multihand_bank.sv
`default_nettype none
// ============================================================================
//  Module      : multihand_bank
//  Description : NUM_HANDS card hands of up to MAX_CARDS cards each. A
//                free-running 1..13 deal counter supplies the current card,
//                which is appended to a hand on a valid/ready handshake.
//                Each hand keeps an incremental baccarat score (mod 10),
//                a card count, full/natural flags, and a registered read
//                port for display logic.
//  Ports       : clk   - clock, all state updates on rising edge
//                reset - synchronous active-high reset
//                bus   - slave side of multihand_bank_if (deal/clear
//                        requests, read port, current card, status vectors)
//  Revision    : 1.0 - initial release
// ============================================================================
module multihand_bank #(
    parameter int NUM_HANDS = 2,
    parameter int MAX_CARDS = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    multihand_bank_if.slave  bus
);
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
    localparam int SW = (MAX_CARDS > 1) ? $clog2(MAX_CARDS) : 1;
    localparam int CW = $clog2(MAX_CARDS + 1);

    // Architectural state
    logic [3:0]    slot_q  [NUM_HANDS][MAX_CARDS];
    logic [CW-1:0] count_q [NUM_HANDS];
    logic [3:0]    score_q [NUM_HANDS];
    logic [3:0]    card_q;
    logic [3:0]    card_d;
    logic [3:0]    rd_card_q;
    logic [3:0]    rd_card_d;

    // Per-hand combinational terms
    logic [NUM_HANDS-1:0] w_full;
    logic [NUM_HANDS-1:0] w_clear_hit;
    logic [NUM_HANDS-1:0] w_deal_ok;
    logic [NUM_HANDS-1:0] w_deal_acc;
    logic [4:0]           w_sum     [NUM_HANDS];
    logic [3:0]           w_score_d [NUM_HANDS];
    logic [3:0]           w_card_val;

    // Face cards and tens are worth zero in baccarat.
    assign w_card_val = (card_q <= 4'd9) ? card_q : 4'd0;
    assign card_d     = (card_q == 4'd13) ? 4'd1 : card_q + 4'd1;

    genvar h;
    generate
        for (h = 0; h < NUM_HANDS; h++) begin : g_hand
            assign w_full[h]      = (count_q[h] == CW'(MAX_CARDS));
            assign w_clear_hit[h] = bus.clear_valid && (bus.clear_hand == HW'(h));
            // A hand index with no matching hand never sets any bit here,
            // so out-of-range deal_hand yields deal_ready = 0 naturally.
            assign w_deal_ok[h]   = (bus.deal_hand == HW'(h)) && !w_full[h]
                                    && !w_clear_hit[h];
            assign w_deal_acc[h]  = bus.deal_valid && w_deal_ok[h];

            // Both operands are 0..9, so one conditional subtract suffices.
            assign w_sum[h]     = {1'b0, score_q[h]} + {1'b0, w_card_val};
            assign w_score_d[h] = (w_sum[h] >= 5'd10) ? (w_sum[h][3:0] - 4'd10)
                                                      : w_sum[h][3:0];

            assign bus.score_out[4*h +: 4]   = score_q[h];
            assign bus.count_out[CW*h +: CW] = count_q[h];
            assign bus.full_out[h]           = w_full[h];
            assign bus.natural_out[h]        = (count_q[h] == CW'(2))
                                               && ((score_q[h] == 4'd8) || (score_q[h] == 4'd9));
        end
    endgenerate

    assign bus.deal_ready = |w_deal_ok;
    assign bus.new_card   = card_q;
    assign bus.rd_card    = rd_card_q;

    // Uncounted slots read as zero, which also covers a slot being written
    // in the same cycle since its count has not yet advanced.
    always_comb begin
        rd_card_d = 4'd0;
        for (int hh = 0; hh < NUM_HANDS; hh++) begin
            for (int s = 0; s < MAX_CARDS; s++) begin
                if ((bus.rd_hand == HW'(hh)) && (bus.rd_slot == SW'(s))
                    && (CW'(s) < count_q[hh])) begin
                    rd_card_d = slot_q[hh][s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            card_q    <= 4'd1;
            rd_card_q <= 4'd0;
            for (int hh = 0; hh < NUM_HANDS; hh++) begin
                count_q[hh] <= '0;
                score_q[hh] <= 4'd0;
                for (int s = 0; s < MAX_CARDS; s++) begin
                    slot_q[hh][s] <= 4'd0;
                end
            end
        end else begin
            card_q    <= card_d;
            rd_card_q <= rd_card_d;
            for (int hh = 0; hh < NUM_HANDS; hh++) begin
                if (w_clear_hit[hh]) begin
                    count_q[hh] <= '0;
                    score_q[hh] <= 4'd0;
                    for (int s = 0; s < MAX_CARDS; s++) begin
                        slot_q[hh][s] <= 4'd0;
                    end
                end else if (w_deal_acc[hh]) begin
                    count_q[hh] <= count_q[hh] + CW'(1);
                    score_q[hh] <= w_score_d[hh];
                    for (int s = 0; s < MAX_CARDS; s++) begin
                        if (count_q[hh] == CW'(s)) begin
                            slot_q[hh][s] <= card_q;
                        end
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_multihand_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multihand_bank
//  Description : Directed self-checking bench for multihand_bank. Expected
//                values are queued when stimulus is applied and popped when
//                the corresponding DUT output is sampled.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multihand_bank;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multihand_bank_if #(.NUM_HANDS(2), .MAX_CARDS(3)) bus_a ();
    multihand_bank_if #(.NUM_HANDS(3), .MAX_CARDS(3)) bus_b ();

    multihand_bank #(.NUM_HANDS(2), .MAX_CARDS(3)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    multihand_bank #(.NUM_HANDS(3), .MAX_CARDS(3)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          m_card;
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [3:0]  exp_slot [3];

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=<queued value>", obs);
        end
        if (exp_q.size() != 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    function automatic logic [31:0] cnt(input int h);
        return 32'(bus_a.count_out[CW*h +: CW]);
    endfunction

    function automatic logic [31:0] scr(input int h);
        return 32'(bus_a.score_out[4*h +: 4]);
    endfunction

    // Advance one edge and keep the reference deal counter in step.
    task automatic tick();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) m_card = 1;
        else   m_card = (m_card == 13) ? 1 : m_card + 1;
    endtask

    task automatic hand_chk(input int h, input int c, input int s,
                            input logic f, input logic n);
        push_exp($sformatf("count%0d", h), c);
        push_exp($sformatf("score%0d", h), s);
        push_exp($sformatf("full%0d", h), 32'(f));
        push_exp($sformatf("natural%0d", h), 32'(n));
        pop_chk(cnt(h));
        pop_chk(scr(h));
        pop_chk(32'(bus_a.full_out[h]));
        pop_chk(32'(bus_a.natural_out[h]));
    endtask

    task automatic wait_card(input int k);
        int n = 0;
        while (m_card != k && n < 20) begin
            tick();
            n++;
        end
        push_exp("new_card", k);
        pop_chk(32'(bus_a.new_card));
    endtask

    task automatic deal(input int h, input int k);
        wait_card(k);
        bus_a.deal_valid = 1'b1;
        bus_a.deal_hand  = h[0:0];
        #1;
        push_exp("deal_ready", 1);
        pop_chk(32'(bus_a.deal_ready));
        tick();
        bus_a.deal_valid = 1'b0;
    endtask

    task automatic read_chk(input int h, input int s, input int v);
        bus_a.rd_hand = h[0:0];
        bus_a.rd_slot = s[1:0];
        push_exp($sformatf("rd_card_h%0d_s%0d", h, s), v);
        tick();
        pop_chk(32'(bus_a.rd_card));
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset             = 1'b1;
        m_card            = 1;
        bus_a.deal_valid  = 1'b0;
        bus_a.deal_hand   = '0;
        bus_a.clear_valid = 1'b0;
        bus_a.clear_hand  = '0;
        bus_a.rd_hand     = '0;
        bus_a.rd_slot     = '0;
        bus_b.deal_valid  = 1'b0;
        bus_b.deal_hand   = '0;
        bus_b.clear_valid = 1'b0;
        bus_b.clear_hand  = '0;
        bus_b.rd_hand     = '0;
        bus_b.rd_slot     = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        hand_chk(0, 0, 0, 1'b0, 1'b0);
        hand_chk(1, 0, 0, 1'b0, 1'b0);
        push_exp("reset_rd_card", 0);
        push_exp("reset_new_card", 1);
        pop_chk(32'(bus_a.rd_card));
        pop_chk(32'(bus_a.new_card));

        // Hand 0 gets 7 and 12
        deal(0, 7);
        deal(0, 12);
        hand_chk(0, 2, 7, 1'b0, 1'b0);
        read_chk(0, 0, 7);
        read_chk(0, 1, 12);

        // Hand 1 gets 9, 8, then 13 and fills
        deal(1, 9);
        deal(1, 8);
        hand_chk(1, 2, 7, 1'b0, 1'b0);
        deal(1, 13);
        hand_chk(1, 3, 7, 1'b1, 1'b0);

        // Fresh hand 0: 4 + 5 is a natural nine, then 3 wraps to 2
        bus_a.clear_valid = 1'b1;
        bus_a.clear_hand  = 1'b0;
        tick();
        bus_a.clear_valid = 1'b0;
        hand_chk(0, 0, 0, 1'b0, 1'b0);
        deal(0, 4);
        deal(0, 5);
        hand_chk(0, 2, 9, 1'b0, 1'b1);
        deal(0, 3);
        hand_chk(0, 3, 2, 1'b1, 1'b0);

        // Full hand refuses deals for several cycles
        bus_a.deal_valid = 1'b1;
        bus_a.deal_hand  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            push_exp("full_deal_ready", 0);
            pop_chk(32'(bus_a.deal_ready));
            tick();
        end
        bus_a.deal_valid = 1'b0;
        hand_chk(0, 3, 2, 1'b1, 1'b0);
        exp_slot = '{4'd4, 4'd5, 4'd3};
        for (int s = 0; s < 3; s++) read_chk(0, s, 32'(exp_slot[s]));
        read_chk(1, 2, 13);
        bus_a.clear_valid = 1'b1;
        bus_a.clear_hand  = 1'b1;
        tick();
        bus_a.clear_valid = 1'b0;
        read_chk(1, 2, 0);

        // Clear and deal to the same hand: clear wins
        bus_a.clear_valid = 1'b1;
        bus_a.clear_hand  = 1'b0;
        bus_a.deal_valid  = 1'b1;
        bus_a.deal_hand   = 1'b0;
        #1;
        push_exp("clear_same_ready", 0);
        pop_chk(32'(bus_a.deal_ready));
        tick();
        bus_a.clear_valid = 1'b0;
        bus_a.deal_valid  = 1'b0;
        hand_chk(0, 0, 0, 1'b0, 1'b0);

        // Clear hand 0 while dealing 6 to hand 1 and reading the slot being written
        wait_card(6);
        bus_a.clear_valid = 1'b1;
        bus_a.clear_hand  = 1'b0;
        bus_a.deal_valid  = 1'b1;
        bus_a.deal_hand   = 1'b1;
        bus_a.rd_hand     = 1'b1;
        bus_a.rd_slot     = 2'd0;
        #1;
        push_exp("clear_other_ready", 1);
        pop_chk(32'(bus_a.deal_ready));
        push_exp("rd_same_cycle_write", 0);
        tick();
        bus_a.clear_valid = 1'b0;
        bus_a.deal_valid  = 1'b0;
        pop_chk(32'(bus_a.rd_card));
        hand_chk(1, 1, 6, 1'b0, 1'b0);
        read_chk(1, 0, 6);

        // Counter wrap 13 -> 1, then mid-sequence reset drops a pending deal
        wait_card(13);
        tick();
        push_exp("wrap_new_card", 1);
        pop_chk(32'(bus_a.new_card));
        deal(0, 2);
        deal(0, 3);
        hand_chk(0, 2, 5, 1'b0, 1'b0);
        bus_a.rd_hand    = 1'b0;
        bus_a.rd_slot    = 2'd0;
        bus_a.deal_valid = 1'b1;
        bus_a.deal_hand  = 1'b1;
        reset            = 1'b1;
        tick();
        reset            = 1'b0;
        bus_a.deal_valid = 1'b0;
        hand_chk(0, 0, 0, 1'b0, 1'b0);
        hand_chk(1, 0, 0, 1'b0, 1'b0);
        push_exp("post_reset_new_card", 1);
        push_exp("post_reset_rd_card", 0);
        pop_chk(32'(bus_a.new_card));
        pop_chk(32'(bus_a.rd_card));

        // Three-hand build: hand index 3 is out of range
        bus_b.deal_hand = 2'd3;
        #1;
        push_exp("oob_deal_ready", 0);
        pop_chk(32'(bus_b.deal_ready));
        bus_b.deal_hand = 2'd2;
        #1;
        push_exp("last_hand_deal_ready", 1);
        pop_chk(32'(bus_b.deal_ready));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
